// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU core: sequences core reset, gates the core clock-enable
// (free-run / single-step / breakpoint), counts cycles and detects program end or timeout.
module cpu_run_ctrl #(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 11,
    parameter int HALT_STABLE  = 4,
    parameter int MAX_CYCLES   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             resume,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_rst_n,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state,
    output logic             done,
    output logic             timed_out,
    output logic             bp_hit
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int STAB_W = $clog2(HALT_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_RUN      = 3'd2,
        S_PAUSE    = 3'd3,
        S_DONE     = 3'd4,
        S_TIMEOUT  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STAB_W-1:0]  stable_q, stable_d;
    logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bp_skip_q, bp_skip_d;
    logic               bp_hit_q, bp_hit_d;
    logic               rst_n_q, rst_n_d;
    logic               ce;
    logic               bp_match;

    assign bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stable_d  = stable_q;
        prev_pc_d = prev_pc_q;
        cnt_d     = cnt_q;
        bp_skip_d = bp_skip_q;
        bp_hit_d  = bp_hit_q;
        ce        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d   = S_RST_HOLD;
                    hold_d    = '0;
                    stable_d  = '0;
                    prev_pc_d = pc;
                    cnt_d     = '0;
                    bp_skip_d = 1'b0;
                    bp_hit_d  = 1'b0;
                end
            end
            S_RST_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = step_mode ? S_PAUSE : S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (bp_match) begin
                    state_d  = S_PAUSE;
                    bp_hit_d = 1'b1;
                end else begin
                    ce = 1'b1;
                end
            end
            S_PAUSE: begin
                ce = step;
                if (resume) begin
                    state_d   = S_RUN;
                    bp_skip_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every executed core cycle updates the counters; halt outranks timeout.
        if (ce) begin
            cnt_d     = cnt_q + CNT_W'(1);
            stable_d  = (pc == prev_pc_q) ? stable_q + STAB_W'(1) : '0;
            prev_pc_d = pc;
            bp_skip_d = 1'b0;
            if (stable_d == STAB_W'(HALT_STABLE - 1)) begin
                state_d  = S_DONE;
                bp_hit_d = 1'b0;
            end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
                state_d  = S_TIMEOUT;
                bp_hit_d = 1'b0;
            end
        end

        rst_n_d = !((state_d == S_IDLE) || (state_d == S_RST_HOLD));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            stable_q  <= '0;
            prev_pc_q <= '0;
            cnt_q     <= '0;
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            prev_pc_q <= prev_pc_d;
            cnt_q     <= cnt_d;
            bp_skip_q <= bp_skip_d;
            bp_hit_q  <= bp_hit_d;
            rst_n_q   <= rst_n_d;
        end
    end

    assign cpu_rst_n = rst_n_q;
    assign cpu_ce    = ce;
    assign cycle_cnt = cnt_q;
    assign state     = state_q;
    assign done      = (state_q == S_DONE);
    assign timed_out = (state_q == S_TIMEOUT);
    assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small PC-advancing core model and an
// expected-value scoreboard queue.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        resume;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc = 32'd0;
    logic        cpu_rst_n;
    logic        cpu_ce;
    logic [31:0] cycle_cnt;
    logic [2:0]  state;
    logic        done;
    logic        timed_out;
    logic        bp_hit;

    logic [31:0] pc_base = 32'd0;
    logic [31:0] pc_cap  = 32'hFFFF_0000;
    int          ce_cnt  = 0;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    cpu_run_ctrl #(
        .PC_W(32), .CNT_W(32), .RESET_CYCLES(11), .HALT_STABLE(4), .MAX_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step(step), .resume(resume), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_rst_n(cpu_rst_n), .cpu_ce(cpu_ce), .cycle_cnt(cycle_cnt), .state(state),
        .done(done), .timed_out(timed_out), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    // Core model: PC held at pc_base in reset, advances by 4 per enabled cycle up to pc_cap.
    always @(posedge clk) begin
        if (cpu_rst_n !== 1'b1)   pc <= pc_base;
        else if (cpu_ce === 1'b1) pc <= (pc >= pc_cap) ? pc_cap : pc + 32'd4;
    end

    always @(posedge clk) begin
        if (cpu_ce === 1'b1) ce_cnt <= ce_cnt + 1;
    end

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string t);
        int n;
        n = 0;
        push_exp(t, {29'd0, target});
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        check({29'd0, state});
    endtask

    initial begin
        int   n;
        int   ce_base;
        logic rst_bad;

        reset = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
        bp_en = 1'b0; bp_addr = 32'd0;
        pc_base = 32'd4; pc_cap = 32'h50;

        // Reset state
        repeat (3) tick();
        push_exp("rst_state", 0);      check({29'd0, state});
        push_exp("rst_cpu_rst_n", 0);  check({31'd0, cpu_rst_n});
        push_exp("rst_cycle_cnt", 0);  check(cycle_cnt);
        push_exp("rst_cpu_ce", 0);     check({31'd0, cpu_ce});
        reset = 1'b1;
        tick();
        push_exp("idle_state", 0);     check({29'd0, state});

        // Reset release sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp("hold_state", 1);     check({29'd0, state});
        n = 0; rst_bad = 1'b0;
        while (state === 3'd1 && n < 40) begin
            if (cpu_rst_n !== 1'b0 || cpu_ce !== 1'b0) rst_bad = 1'b1;
            n++;
            tick();
        end
        push_exp("hold_cycles", 11);   check(n);
        push_exp("hold_core_low", 0);  check({31'd0, rst_bad});
        push_exp("run_state", 2);      check({29'd0, state});
        push_exp("run_cpu_rst_n", 1);  check({31'd0, cpu_rst_n});
        push_exp("run_cpu_ce", 1);     check({31'd0, cpu_ce});

        // Halt detection: PC climbs to 0x50 and sticks
        wait_state(3'd4, 100, "halt_state");
        push_exp("halt_cnt", 23);      check(cycle_cnt);
        push_exp("halt_done", 1);      check({31'd0, done});
        push_exp("halt_ce", 0);        check({31'd0, cpu_ce});
        push_exp("halt_rst_n", 1);     check({31'd0, cpu_rst_n});
        for (int i = 0; i < 10; i++) begin
            tick();
            push_exp("halt_frozen_cnt", 23); check(cycle_cnt);
        end

        // Breakpoint at 0x10
        pc_base = 32'd0; pc_cap = 32'hFFFF_0000;
        bp_en = 1'b1; bp_addr = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp("restart_cnt", 0);    check(cycle_cnt);
        wait_state(3'd3, 100, "bp_state");
        push_exp("bp_hit", 1);         check({31'd0, bp_hit});
        push_exp("bp_ce", 0);          check({31'd0, cpu_ce});
        push_exp("bp_pc", 32'h10);     check(pc);
        push_exp("bp_cnt", 4);         check(cycle_cnt);
        tick(); tick();
        push_exp("bp_hold_cnt", 4);    check(cycle_cnt);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        push_exp("resume_state", 2);   check({29'd0, state});
        push_exp("resume_ce", 1);      check({31'd0, cpu_ce});
        push_exp("resume_bp_hit", 0);  check({31'd0, bp_hit});
        tick();
        push_exp("resume_pc", 32'h14); check(pc);
        push_exp("resume_cnt", 5);     check(cycle_cnt);
        push_exp("no_retrap", 2);      check({29'd0, state});
        bp_en = 1'b0;

        // Timeout at 50 enabled cycles
        wait_state(3'd5, 100, "to_state");
        push_exp("to_flag", 1);        check({31'd0, timed_out});
        push_exp("to_done", 0);        check({31'd0, done});
        push_exp("to_cnt", 50);        check(cycle_cnt);
        push_exp("to_ce", 0);          check({31'd0, cpu_ce});
        repeat (3) tick();
        push_exp("to_frozen_cnt", 50); check(cycle_cnt);

        // Single-step from restart
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp("to_restart_state", 1); check({29'd0, state});
        push_exp("to_restart_cnt", 0);   check(cycle_cnt);
        wait_state(3'd3, 40, "ss_state");
        push_exp("ss_ce", 0);          check({31'd0, cpu_ce});
        push_exp("ss_bp_hit", 0);      check({31'd0, bp_hit});
        ce_base = ce_cnt;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        push_exp("ss_ce_pulses", 3);   check(ce_cnt - ce_base);
        push_exp("ss_cnt", 3);         check(cycle_cnt);
        push_exp("ss_still_pause", 3); check({29'd0, state});
        step = 1'b1; resume = 1'b1;
        tick();
        step = 1'b0; resume = 1'b0;
        push_exp("ss_resume_state", 2); check({29'd0, state});
        push_exp("ss_resume_cnt", 4);   check(cycle_cnt);

        // Asynchronous reset mid-run
        n = 0;
        while (cycle_cnt !== 32'd30 && n < 100) begin
            tick();
            n++;
        end
        push_exp("mid_cnt", 30);       check(cycle_cnt);
        #3;
        reset = 1'b0;
        #1;
        push_exp("async_state", 0);    check({29'd0, state});
        push_exp("async_rst_n", 0);    check({31'd0, cpu_rst_n});
        push_exp("async_cnt", 0);      check(cycle_cnt);
        push_exp("async_ce", 0);       check({31'd0, cpu_ce});
        tick();
        reset = 1'b1;
        tick(); tick();
        push_exp("post_reset_idle", 0); check({29'd0, state});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
